// File: rtl/wb_target_mem.sv
// Wishbone classic (B3) target memory with configurable wait states, byte-lane writes
// and error termination for addresses outside the decoded window.
module wb_target_mem #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            DEPTH_LOG2  = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned            WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [3:0]            sel_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  busy_o
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned LANES     = DATA_WIDTH / 8;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state;
    logic [3:0]              wait_cnt;
    logic                    lat_we;
    logic [3:0]              lat_sel;
    logic [ADDR_WIDTH-1:2]   lat_adr;
    logic [DATA_WIDTH-1:0]   lat_dat;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   word_idx;
    logic                    hit;
    logic                    mem_we;
    logic                    unused_adr_bits;

    assign unused_adr_bits = &{1'b0, adr_i[1:0]};

    assign word_idx = lat_adr[DEPTH_LOG2+1:2];
    assign hit      = (lat_adr[ADDR_WIDTH-1:DEPTH_LOG2+2] == BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2+2]);
    assign mem_we   = (state == S_RESP) && lat_we && hit;
    assign busy_o   = (state != S_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            lat_we   <= 1'b0;
            lat_sel  <= '0;
            lat_adr  <= '0;
            lat_dat  <= '0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            dat_o    <= '0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cyc_i && stb_i) begin
                        lat_we  <= we_i;
                        lat_sel <= sel_i;
                        lat_adr <= adr_i[ADDR_WIDTH-1:2];
                        lat_dat <= dat_i;
                        if (WAIT_STATES > 0) begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    // Abort takes priority over counter expiry
                    if (!cyc_i) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    if (hit) begin
                        ack_o <= 1'b1;
                        if (!lat_we) begin
                            dat_o <= mem[word_idx];
                        end
                    end else begin
                        err_o <= 1'b1;
                        dat_o <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory array carries no reset; contents persist across resets
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < LANES; b++) begin
                if (lat_sel[b]) begin
                    mem[word_idx][8*b +: 8] <= lat_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_target_mem.sv
// Self-checking bench for wb_target_mem: three instances (1, 3 and 0 wait states)
// driven by directed vectors, corner-case sequences and random traffic.
module tb_wb_target_mem;

    localparam int          NDUT  = 3;
    localparam int          WS [NDUT] = '{1, 3, 0};
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          WORDS = 256;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        cyc  [NDUT];
    logic        stb  [NDUT];
    logic        we   [NDUT];
    logic [3:0]  sel  [NDUT];
    logic [31:0] adr  [NDUT];
    logic [31:0] wdat [NDUT];
    logic [31:0] rdat [NDUT];
    logic        ack  [NDUT];
    logic        err  [NDUT];
    logic        busy [NDUT];

    wb_target_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(8),
                    .BASE_ADDR(32'h3000_0000), .WAIT_STATES(1)) u_ws1 (
        .clock(clock), .reset(reset), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
        .sel_i(sel[0]), .adr_i(adr[0]), .dat_i(wdat[0]), .ack_o(ack[0]), .err_o(err[0]),
        .dat_o(rdat[0]), .busy_o(busy[0]));

    wb_target_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(8),
                    .BASE_ADDR(32'h3000_0000), .WAIT_STATES(3)) u_ws3 (
        .clock(clock), .reset(reset), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
        .sel_i(sel[1]), .adr_i(adr[1]), .dat_i(wdat[1]), .ack_o(ack[1]), .err_o(err[1]),
        .dat_o(rdat[1]), .busy_o(busy[1]));

    wb_target_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(8),
                    .BASE_ADDR(32'h3000_0000), .WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset(reset), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]),
        .sel_i(sel[2]), .adr_i(adr[2]), .dat_i(wdat[2]), .ack_o(ack[2]), .err_o(err[2]),
        .dat_o(rdat[2]), .busy_o(busy[2]));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference memory image, one per instance
    logic [31:0] model [NDUT][WORDS];

    typedef struct {
        bit          w;
        logic [3:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        bit          exp_ack;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(WORDS * 4));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Drives one transfer starting at the current negedge and returns at the
    // negedge where the termination is visible; hold keeps the request asserted.
    task automatic xfer(input int k, input bit w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d, input bit hold);
        bit          hit;
        logic [31:0] exp_d;
        int          n;
        bit          done;
        hit   = in_win(a);
        exp_d = hit ? model[k][word_of(a)] : 32'h0;
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; wdat[k] = d;
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
            if (ack[k] || err[k]) begin
                done = 1'b1;
            end else begin
                check("busy_while_pending", busy[k], 1'b1);
            end
        end
        if (!done) begin
            check("termination_timeout", 32'(n), 32'(2 + WS[k]));
        end else begin
            check("latency", 32'(n), 32'(2 + WS[k]));
            check("ack", ack[k], hit);
            check("err", err[k], !hit);
            check("busy_at_term", busy[k], 1'b0);
            if (!w || !hit) check("dat_o", rdat[k], exp_d);
            if (w && hit) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) model[k][word_of(a)][8*b +: 8] = d[8*b +: 8];
            end
        end
        if (!hold) begin
            cyc[k] = 1'b0; stb[k] = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int k = 0; k < NDUT; k++) begin
            check({name, "_ack"},  ack[k],  1'b0);
            check({name, "_err"},  err[k],  1'b0);
            check({name, "_busy"}, busy[k], 1'b0);
            check({name, "_dat"},  rdat[k], 32'h0);
        end
    endtask

    initial begin
        logic [31:0] prior;
        logic [31:0] a;
        bit          w;
        bit          hold;

        tbl[0]  = '{1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 4'hF, 32'h3000_0010, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 4'hF, 32'h3000_0020, 32'h1122_3344, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 4'h5, 32'h3000_0020, 32'hAABB_CCDD, 1'b1, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 4'h0, 32'h3000_0020, 32'h0,         1'b1, 1'b1, 32'h11BB_33DD};
        tbl[5]  = '{1'b1, 4'hF, 32'h3000_0000, 32'h0102_0304, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 4'hF, 32'h3000_0400, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0};
        tbl[7]  = '{1'b0, 4'hF, 32'h3000_0400, 32'h0,         1'b0, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, 4'hF, 32'h3000_0000, 32'h0,         1'b1, 1'b1, 32'h0102_0304};
        tbl[9]  = '{1'b0, 4'hF, 32'h3000_0013, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF};
        tbl[10] = '{1'b1, 4'hF, 32'h2FFF_FFFC, 32'h5555_5555, 1'b0, 1'b1, 32'h0};

        for (int k = 0; k < NDUT; k++) begin
            cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            sel[k] = 4'h0; adr[k] = 32'h0; wdat[k] = 32'h0;
        end
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset_value");
        reset = 1'b1;
        @(negedge clock);

        // Give every word a known value so the model is fully defined
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < WORDS; i++)
                xfer(k, 1'b1, 4'hF, BASE + 32'(4 * i), $urandom, 1'b0);

        for (int i = 0; i < 11; i++) begin
            xfer(0, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, 1'b0);
            check("vec_ack", ack[0], tbl[i].exp_ack);
            if (tbl[i].chk_rd) check("vec_data", rdat[0], tbl[i].exp_rd);
        end

        // stb without cyc must be ignored
        stb[0] = 1'b1; we[0] = 1'b1; adr[0] = BASE; wdat[0] = 32'hBAD0_BAD0; sel[0] = 4'hF;
        repeat (4) begin
            @(negedge clock);
            check("stb_only_busy", busy[0], 1'b0);
            check("stb_only_term", ack[0] | err[0], 1'b0);
        end
        stb[0] = 1'b0;
        xfer(0, 1'b0, 4'hF, BASE, 32'h0, 1'b0);

        // Abort: cyc dropped after one wait cycle on the 3-wait-state instance
        prior = model[1][5];
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF;
        adr[1] = BASE + 32'd20; wdat[1] = ~prior;
        @(negedge clock);
        check("abort_busy_wait", busy[1], 1'b1);
        @(negedge clock);
        check("abort_busy_before_drop", busy[1], 1'b1);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clock);
        check("abort_busy_fall", busy[1], 1'b0);
        repeat (6) begin
            @(negedge clock);
            check("abort_no_term", ack[1] | err[1], 1'b0);
        end
        xfer(1, 1'b0, 4'hF, BASE + 32'd20, 32'h0, 1'b0);
        check("abort_prior_value", rdat[1], prior);

        // Reset asserted while in WAIT
        prior = model[1][7];
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF;
        adr[1] = BASE + 32'd28; wdat[1] = ~prior;
        @(negedge clock);
        check("pre_reset_busy", busy[1], 1'b1);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        xfer(1, 1'b0, 4'hF, BASE + 32'd28, 32'h0, 1'b0);
        check("reset_dropped_write", rdat[1], prior);

        // Zero wait states, back-to-back with the request held high
        for (int i = 0; i < 8; i++)
            xfer(2, 1'b1, 4'hF, BASE + 32'(4 * (100 + i)), $urandom, 1'b1);
        for (int i = 0; i < 8; i++)
            xfer(2, 1'b0, 4'hF, BASE + 32'(4 * (100 + i)), 32'h0, (i != 7));

        // Random traffic against the reference image
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 60; i++) begin
                case ($urandom_range(7))
                    0:       a = BASE + 32'd1024 + $urandom_range(4095);
                    1:       a = BASE - 32'd4 - 32'($urandom_range(4095));
                    default: a = BASE + 32'(4 * $urandom_range(WORDS - 1)) + 32'($urandom_range(3));
                endcase
                w    = 1'($urandom_range(1));
                hold = (i != 59) && ($urandom_range(1) == 1);
                xfer(k, w, 4'($urandom_range(15)), a, $urandom, hold);
            end
        end

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_target_mem.md
# wb_target_mem

Synthesizable Wishbone classic (B3, non-pipelined) target: a word-addressed memory behind the user-project Wishbone slave port, answering the transactions that `wb_initiator_bfm` issues. It inserts a parameterizable number of wait states, honours byte selects, and signals `err_o` for addresses outside its window. It serves as the default target when bringing up the initiator path and as a memory-mapped scratch region inside the user project.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width.
- `DATA_WIDTH`, 32, data width; must be 32 (4 byte lanes).
- `DEPTH_LOG2`, 8, log2 of the number of memory words (256 words = 1 KiB).
- `BASE_ADDR`, 32'h3000_0000, window base; must be aligned to 2^(DEPTH_LOG2+2).
- `WAIT_STATES`, 1, extra cycles inserted before the response; legal range 0..15.

Ports:
- `clock`, in, 1, sole clock; every register is clocked on its rising edge.
- `reset`, in, 1, asynchronous, active-low.
- `cyc_i`, in, 1, bus cycle valid.
- `stb_i`, in, 1, strobe.
- `we_i`, in, 1, 1 = write, 0 = read.
- `sel_i`, in, 4, byte-lane enables; bit n covers dat bits [8n+7:8n].
- `adr_i`, in, ADDR_WIDTH, byte address; bits [1:0] are ignored.
- `dat_i`, in, DATA_WIDTH, write data.
- `ack_o`, out, 1, normal termination; one-cycle pulse.
- `err_o`, out, 1, error termination; one-cycle pulse.
- `dat_o`, out, DATA_WIDTH, read data.
- `busy_o`, out, 1, high while a request is accepted but not yet terminated.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE → request when `cyc_i & stb_i` is high:
  - Latch `we_i`, `sel_i`, `adr_i`, `dat_i`.
  - Go to WAIT if `WAIT_STATES > 0` (counter loaded with `WAIT_STATES-1`); otherwise go straight to RESP.
- WAIT:
  - Decrement the counter each cycle; go to RESP when it reaches 0.
  - If `cyc_i` drops, abort: return to IDLE, no termination, no write.
- RESP lasts one cycle, then returns to IDLE unconditionally. The request inputs are not sampled in RESP.
- Address decode:
  - Hit when `adr_i[ADDR_WIDTH-1:DEPTH_LOG2+2] == BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2+2]`.
  - Word index = `adr_i[DEPTH_LOG2+1:2]`.
- Response on a hit (`ack_o`):
  - Write: memory updated only on lanes whose `sel_i` bit is 1, at the same edge that raises `ack_o`.
  - Read: `dat_o` = full 32-bit word regardless of `sel_i`.
- Response on a miss (`err_o`): no memory update; `dat_o` = 0.
- `ack_o` and `err_o` are registered, mutually exclusive, and never high in consecutive cycles.
- `dat_o` holds its last value outside RESP.
- Memory contents are not reset (undefined until written).

## Timing
- Reset values: `ack_o`=0, `err_o`=0, `busy_o`=0, `dat_o`=0, state IDLE, counter 0.
- Reset asserted mid-transaction: FSM returns to IDLE immediately; any pending write is dropped; no termination is issued.
- Latency: request first sampled at edge N → `ack_o`/`err_o` high in the cycle after edge N+1+WAIT_STATES.
  - WAIT_STATES=0: response one cycle after the request is sampled.
  - WAIT_STATES=1: response two cycles after.
- `busy_o` = state ∈ {WAIT, RESP}.
- Back-to-back: the initiator must drop `stb_i` after seeing the termination. A request still asserted in the cycle after RESP is accepted as a new transaction. Maximum throughput is one transfer per 2+WAIT_STATES cycles.
- `stb_i` without `cyc_i` is ignored.
- Inputs are sampled only in IDLE; changes during WAIT/RESP have no effect, except `cyc_i` low in WAIT, which aborts.

## Test plan
- Write 32'hDEAD_BEEF to 32'h3000_0010 (`sel`=4'hF), then read it back → read returns 32'hDEAD_BEEF; with WAIT_STATES=1, `ack_o` appears 2 cycles after `stb_i` is first sampled, for each access.
- Byte lanes: write 32'h1122_3344 (`sel`=F), then 32'hAABB_CCDD with `sel`=4'b0101 to the same word → read returns 32'h11BB_33DD.
- Out of window: write to 32'h3000_0400 (DEPTH_LOG2=8), then read → `err_o` pulses with `ack_o`=0 and `dat_o`=0 on the read; word 0 is unchanged by the write.
- Abort: start a write with WAIT_STATES=3 and drop `cyc_i` after one wait cycle → no `ack_o`/`err_o`; a subsequent read of that word returns its prior value; `busy_o` falls the cycle after the drop.
- Reset mid-WAIT: assert `reset` low during WAIT → all outputs 0 immediately; after release, the next transaction completes with normal latency; the aborted write has no effect.
- WAIT_STATES=0 back-to-back: 8 consecutive writes then 8 reads at incrementing addresses → each response one cycle after its request; all data match; `ack_o` never high in two consecutive cycles.
